pio_ram_emu_link: RTL and testbench
===================================

# pio_ram_emu_link

Parametrised, bidirectional link engine for the PIO RAM emulator protocol. It serialises request frames (header + data) onto IO_BITS transmit pins and deserialises response words from IO_BITS receive pins. It tracks outstanding read requests and gates new reads with a credit rule, so the response FIFO can never overflow. It sits between the design's memory-request logic and the top-level pins, replacing separate fixed 2-bit transmitter and receiver instances.

## Interface
- IO_BITS, 2: pins per direction; must divide HEADER_BITS+DATA_BITS and DATA_BITS
- HEADER_BITS, 4: request header width
- DATA_BITS, 16: request/response data width
- RESP_DEPTH, 4: response FIFO depth and maximum outstanding reads; power of two, at least 2
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid && req_ready
- req_header  in  HEADER_BITS  header field
- req_data  in  DATA_BITS  data field
- req_expects_resp  in  1  1 = read (consumes one credit), 0 = write
- tx_pins  out  IO_BITS  serial transmit pins
- rx_pins  in  IO_BITS  serial receive pins, already synchronised at top level
- resp_valid  out  1  response word available
- resp_ready  in  1  response pop when resp_valid && resp_ready
- resp_data  out  DATA_BITS  FIFO head word
- outstanding  out  $clog2(RESP_DEPTH+1)  reads sent, response not yet received
- err_unexpected  out  1  sticky: response arrived with outstanding==0
- clear_err  in  1  clears err_unexpected

## Operation
- Constants: P = (HEADER_BITS+DATA_BITS)/IO_BITS; N = DATA_BITS/IO_BITS.
- TX frame: one start cycle with tx_pins all-0, then P payload cycles, then one stop cycle with tx_pins all-1.
  - Payload is {data, header}, sent LSB-first, IO_BITS per cycle.
  - Idle pins are all-1.
- TX FSM: IDLE -> START on accept; START -> PAYLOAD; PAYLOAD -> STOP after P cycles.
  - From STOP: -> START if a request is accepted in STOP, otherwise -> IDLE.
- req_ready = (state IDLE or STOP) && (!req_expects_resp || outstanding + fifo_count < RESP_DEPTH).
  - The credit check uses registered values. A FIFO pop frees the credit only from the next cycle.
  - A blocked read also blocks everything behind it; requests are strictly in order.
- RX FSM: IDLE -> PAYLOAD when rx_pins[0]==0. PAYLOAD samples N cycles LSB-first, then -> IDLE.
  - The cycle after the last payload cycle is evaluated as IDLE, so back-to-back frames are accepted.
- On RX completion:
  - If outstanding>0: push the word into the FIFO and decrement outstanding.
  - Otherwise: drop the word and set err_unexpected.
- outstanding increments on an accepted read. An increment and a decrement in the same cycle leave it unchanged.
- clear_err clears err_unexpected. A new error in the same cycle wins, so the flag stays 1.
- The FIFO cannot be full on a push, because of the credit rule. Push and pop in the same cycle are both performed.

## Timing
- Reset (reset_n==0 at a clock edge) forces the following from the next cycle:
  - tx_pins all-1; TX and RX FSMs in IDLE; FIFO empty.
  - resp_valid=0, outstanding=0, err_unexpected=0.
  - req_ready=0 while reset_n==0.
- Reset mid-frame abandons partial TX and RX frames immediately; no stop cycle is emitted.
- Accept at cycle t: start on tx_pins at t+1, payload at t+2..t+P+1, stop at t+P+2.
  - req_ready is high again at t+P+2, giving a back-to-back period of P+2 cycles.
- RX start at cycle s: payload sampled at s+1..s+N.
  - resp_valid=1 at s+N+1 if the FIFO was empty; resp_data is valid in the same cycle.
- FIFO is first-word-fall-through: resp_data is the registered head word.

## Structure
- Package pio_ram_emu_pkg holds:
  - tx_state_t (IDLE, START, PAYLOAD, STOP) and rx_state_t (IDLE, PAYLOAD);
  - frame-length helper functions for P and N.
- One sub-module: pio_ram_emu_resp_fifo (DATA_BITS × RESP_DEPTH, first-word-fall-through, count output).

## Test plan
(IO_BITS=2, HEADER_BITS=4, DATA_BITS=16, RESP_DEPTH=4)
- Write: header 4'h3, data 16'hA5C3, expects=0.
  - tx_pins = 00, 11,00, 11,00,00,11, 01,01,10,10, 11.
  - req_ready low for the 11 cycles after accept; outstanding stays 0.
- Read accepted, then rx start (00) followed by payload for 16'h1234.
  - resp_valid=1 and resp_data=16'h1234 nine cycles after the start cycle.
  - outstanding goes 1->0.
- Four reads with no responses; a 5th read is held.
  - req_ready=0 while outstanding+fifo_count==4.
  - Response arrival alone keeps it blocked; a pop re-enables req_ready on the following cycle.
- Response driven with outstanding==0.
  - err_unexpected=1 and resp_valid stays 0.
  - clear_err pulse clears it; clear_err coinciding with a new unexpected response leaves it 1.
- Read accepted in the same cycle an RX frame completes, with outstanding==1 -> outstanding remains 1 and the FIFO holds the word.
- reset_n low mid-TX payload and mid-RX payload.
  - Next cycle: tx_pins=11, no resp_valid, outstanding=0.
  - A clean frame after reset is received correctly.

Source files
------------

// File: rtl/pio_ram_emu_link_pkg.sv
// Shared types and frame-length helpers for the PIO RAM emulator link.
package pio_ram_emu_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_PAYLOAD,
    TX_STOP
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_PAYLOAD
  } rx_state_t;

  // Number of payload beats in a request frame: {data, header}.
  function automatic int frame_beats(input int header_bits, input int data_bits,
                                     input int io_bits);
    return (header_bits + data_bits) / io_bits;
  endfunction

  // Number of payload beats in a response frame: data only.
  function automatic int data_beats(input int data_bits, input int io_bits);
    return data_bits / io_bits;
  endfunction

endpackage

// File: rtl/pio_ram_emu_link_if.sv
// Request/response handshake bundle between memory-request logic and the link.
interface pio_ram_emu_link_if #(
  parameter int HEADER_BITS = 4,
  parameter int DATA_BITS   = 16
);
  logic                   req_valid;
  logic                   req_ready;
  logic [HEADER_BITS-1:0] req_header;
  logic [DATA_BITS-1:0]   req_data;
  logic                   req_expects_resp;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DATA_BITS-1:0]   resp_data;

  modport master (
    output req_valid, req_header, req_data, req_expects_resp, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_header, req_data, req_expects_resp, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/pio_ram_emu_resp_fifo.sv
// First-word-fall-through response FIFO; head word is read straight from storage.
module pio_ram_emu_resp_fifo #(
  parameter  int DATA_BITS = 16,
  parameter  int DEPTH     = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic                 head_valid,
  output logic [DATA_BITS-1:0] head_data,
  output logic [CW-1:0]        count
);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 do_pop;

  assign do_pop     = pop && (count_reg != '0);
  assign head_valid = (count_reg != '0);
  assign head_data  = mem[rd_ptr_reg];
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pio_ram_emu_link.sv
// Bidirectional PIO RAM emulator link: serialises request frames, deserialises
// response words and limits outstanding reads so the response FIFO never overflows.
module pio_ram_emu_link
  import pio_ram_emu_pkg::*;
#(
  parameter  int IO_BITS     = 2,
  parameter  int HEADER_BITS = 4,
  parameter  int DATA_BITS   = 16,
  parameter  int RESP_DEPTH  = 4,
  localparam int CW          = $clog2(RESP_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_ram_emu_link_if.slave  bus,
  output logic [IO_BITS-1:0] tx_pins,
  input  logic [IO_BITS-1:0] rx_pins,
  output logic [CW-1:0]      outstanding,
  output logic               err_unexpected,
  input  logic               clear_err
);

  localparam int P          = frame_beats(HEADER_BITS, DATA_BITS, IO_BITS);
  localparam int N          = data_beats(DATA_BITS, IO_BITS);
  localparam int FRAME_BITS = HEADER_BITS + DATA_BITS;
  localparam int TCW        = $clog2(P + 1);
  localparam int RCW        = $clog2(N + 1);

  tx_state_t              tx_state_reg, tx_state_next;
  logic [FRAME_BITS-1:0]  tx_shift_reg;
  logic [TCW-1:0]         tx_cnt_reg;
  rx_state_t              rx_state_reg, rx_state_next;
  logic [DATA_BITS-1:0]   rx_shift_reg;
  logic [RCW-1:0]         rx_cnt_reg;
  logic [DATA_BITS-1:0]   rx_word;
  logic                   rx_done;
  logic [CW-1:0]          outstanding_reg, outstanding_next;
  logic                   err_reg;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_valid;
  logic [DATA_BITS-1:0]   fifo_head;
  logic [CW:0]            credit_used;
  logic                   credit_ok;
  logic                   tx_can_accept;
  logic                   accept;
  logic                   rd_inc;
  logic                   rx_match;
  logic                   rx_orphan;

  // Credits count both in-flight reads and words still waiting in the FIFO.
  assign credit_used   = (CW+1)'(outstanding_reg) + (CW+1)'(fifo_count);
  assign credit_ok     = credit_used < (CW+1)'(RESP_DEPTH);
  assign tx_can_accept = (tx_state_reg == TX_IDLE) || (tx_state_reg == TX_STOP);
  assign bus.req_ready = reset_n && tx_can_accept && (!bus.req_expects_resp || credit_ok);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_pins       = '1;
    case (tx_state_reg)
      TX_IDLE: begin
        if (accept) tx_state_next = TX_START;
      end
      TX_START: begin
        tx_pins       = '0;
        tx_state_next = TX_PAYLOAD;
      end
      TX_PAYLOAD: begin
        tx_pins = tx_shift_reg[IO_BITS-1:0];
        if (tx_cnt_reg == TCW'(P - 1)) tx_state_next = TX_STOP;
      end
      TX_STOP: begin
        tx_state_next = accept ? TX_START : TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_reg <= TX_IDLE;
      tx_shift_reg <= '0;
      tx_cnt_reg   <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      if (accept) begin
        tx_shift_reg <= {bus.req_data, bus.req_header};
        tx_cnt_reg   <= '0;
      end else if (tx_state_reg == TX_PAYLOAD) begin
        tx_shift_reg <= tx_shift_reg >> IO_BITS;
        tx_cnt_reg   <= tx_cnt_reg + TCW'(1);
      end
    end
  end

  // Incoming beats enter at the top so the first beat ends up in the LSBs.
  assign rx_word = (rx_shift_reg >> IO_BITS) |
                   (DATA_BITS'(rx_pins) << (DATA_BITS - IO_BITS));

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_done       = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (!rx_pins[0]) rx_state_next = RX_PAYLOAD;
      end
      RX_PAYLOAD: begin
        if (rx_cnt_reg == RCW'(N - 1)) begin
          rx_done       = 1'b1;
          rx_state_next = RX_IDLE;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_reg <= RX_IDLE;
      rx_shift_reg <= '0;
      rx_cnt_reg   <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      if (rx_state_reg == RX_PAYLOAD) begin
        rx_shift_reg <= rx_word;
        rx_cnt_reg   <= rx_done ? '0 : rx_cnt_reg + RCW'(1);
      end else begin
        rx_cnt_reg <= '0;
      end
    end
  end

  assign rd_inc    = accept && bus.req_expects_resp;
  assign rx_match  = rx_done && (outstanding_reg != '0);
  assign rx_orphan = rx_done && (outstanding_reg == '0);

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({rd_inc, rx_match})
      2'b10:   outstanding_next = outstanding_reg + CW'(1);
      2'b01:   outstanding_next = outstanding_reg - CW'(1);
      default: outstanding_next = outstanding_reg;
    endcase
  end

  // A fresh orphan response outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (rx_orphan) begin
        err_reg <= 1'b1;
      end else if (clear_err) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign outstanding    = outstanding_reg;
  assign err_unexpected = err_reg;

  pio_ram_emu_resp_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (RESP_DEPTH)
  ) u_resp_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (rx_match),
    .push_data  (rx_word),
    .pop        (bus.resp_ready),
    .head_valid (fifo_valid),
    .head_data  (fifo_head),
    .count      (fifo_count)
  );

  assign bus.resp_valid = fifo_valid;
  assign bus.resp_data  = fifo_head;

endmodule

// File: tb/tb_pio_ram_emu_link.sv
// Directed bench for pio_ram_emu_link with a response scoreboard queue.
module tb_pio_ram_emu_link;

  localparam int IO_BITS     = 2;
  localparam int HEADER_BITS = 4;
  localparam int DATA_BITS   = 16;
  localparam int RESP_DEPTH  = 4;
  localparam int N           = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] tx_pins;
  logic [1:0] rx_pins;
  logic [2:0] outstanding;
  logic       err_unexpected;
  logic       clear_err;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [1:0]  exp_tx [12];

  always #5 clk = ~clk;

  pio_ram_emu_link_if #(.HEADER_BITS(HEADER_BITS), .DATA_BITS(DATA_BITS)) bus ();

  pio_ram_emu_link #(
    .IO_BITS     (IO_BITS),
    .HEADER_BITS (HEADER_BITS),
    .DATA_BITS   (DATA_BITS),
    .RESP_DEPTH  (RESP_DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus.slave),
    .tx_pins        (tx_pins),
    .rx_pins        (rx_pins),
    .outstanding    (outstanding),
    .err_unexpected (err_unexpected),
    .clear_err      (clear_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a request and wait (bounded) until it is accepted.
  task automatic send_req(input logic [3:0] h, input logic [15:0] d, input logic e);
    int n;
    bus.req_header       = h;
    bus.req_data         = d;
    bus.req_expects_resp = e;
    bus.req_valid        = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready && n < 64) begin
      tick();
      #1;
      n++;
    end
    chk("req_accept", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid        = 1'b0;
    bus.req_expects_resp = 1'b0;
  endtask

  // Drive one response frame; act=1 pulses clear_err and act=2 offers a read
  // in the completion cycle. Returns in the cycle after the last payload beat.
  task automatic rx_frame(input logic [15:0] w, input bit push, input int act);
    rx_pins = 2'b00;
    tick();
    for (int k = 0; k < N; k++) begin
      rx_pins = w[2*k +: 2];
      if (k == N - 1) begin
        if (act == 1) clear_err = 1'b1;
        if (act == 2) begin
          bus.req_expects_resp = 1'b1;
          bus.req_valid        = 1'b1;
          #1;
          chk("coincident_read_ready", 32'(bus.req_ready), 32'd1);
        end
      end
      tick();
    end
    rx_pins              = 2'b11;
    clear_err            = 1'b0;
    bus.req_valid        = 1'b0;
    bus.req_expects_resp = 1'b0;
    if (push) exp_q.push_back(w);
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] exp_w;
    #1;
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s_scoreboard observed=pop expected=no_pending_word", tag);
    end else begin
      exp_w = exp_q.pop_front();
      chk({tag, "_data"}, 32'(bus.resp_data), 32'(exp_w));
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_tx = '{2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11,
               2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
    reset_n              = 1'b0;
    rx_pins              = 2'b11;
    clear_err            = 1'b0;
    bus.req_valid        = 1'b0;
    bus.req_header       = '0;
    bus.req_data         = '0;
    bus.req_expects_resp = 1'b0;
    bus.resp_ready       = 1'b0;

    // Reset state, with a write offered while reset is held.
    tick();
    tick();
    bus.req_valid = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_tx_pins", 32'(tx_pins), 32'h3);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_err", 32'(err_unexpected), 32'd0);
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // Write frame on the pins.
    send_req(4'h3, 16'hA5C3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("tx_beat%0d", i), 32'(tx_pins), 32'(exp_tx[i]));
      chk($sformatf("tx_ready%0d", i), 32'(bus.req_ready), (i < 11) ? 32'd0 : 32'd1);
      tick();
    end
    chk("tx_idle_pins", 32'(tx_pins), 32'h3);
    chk("write_outstanding", 32'(outstanding), 32'd0);

    // Single read and its response.
    send_req(4'h1, 16'h0042, 1'b1);
    chk("read_outstanding1", 32'(outstanding), 32'd1);
    repeat (12) tick();
    rx_frame(16'h1234, 1'b1, 0);
    #1;
    chk("read_outstanding0", 32'(outstanding), 32'd0);
    pop_check("read_resp");
    chk("read_empty", 32'(bus.resp_valid), 32'd0);

    // Credit exhaustion.
    for (int j = 0; j < 4; j++) send_req(4'h2, 16'(j), 1'b1);
    chk("credit_outstanding4", 32'(outstanding), 32'd4);
    bus.req_header       = 4'h5;
    bus.req_data         = 16'h0005;
    bus.req_expects_resp = 1'b1;
    bus.req_valid        = 1'b1;
    repeat (12) tick();
    #1;
    chk("credit_blocked", 32'(bus.req_ready), 32'd0);
    rx_frame(16'hBEEF, 1'b1, 0);
    bus.req_expects_resp = 1'b1;
    bus.req_valid        = 1'b1;
    #1;
    chk("credit_after_resp_out", 32'(outstanding), 32'd3);
    chk("credit_after_resp_ready", 32'(bus.req_ready), 32'd0);
    chk("credit_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("credit_resp_data", 32'(bus.resp_data), 32'(exp_q.pop_front()));
    bus.resp_ready = 1'b1;
    #1;
    chk("credit_pop_same_cycle", 32'(bus.req_ready), 32'd0);
    tick();
    bus.resp_ready = 1'b0;
    #1;
    chk("credit_pop_next_cycle", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid        = 1'b0;
    bus.req_expects_resp = 1'b0;
    #1;
    chk("credit_refill", 32'(outstanding), 32'd4);
    chk("credit_fifo_empty", 32'(bus.resp_valid), 32'd0);
    repeat (12) tick();
    for (int j = 0; j < 4; j++) rx_frame({4'hD, 4'(j), 8'h3C}, 1'b1, 0);
    #1;
    chk("drain_outstanding", 32'(outstanding), 32'd0);
    for (int j = 0; j < 4; j++) pop_check($sformatf("drain%0d", j));

    // Unexpected responses and clear_err priority.
    rx_frame(16'h0F0F, 1'b0, 0);
    #1;
    chk("orphan_err", 32'(err_unexpected), 32'd1);
    chk("orphan_no_valid", 32'(bus.resp_valid), 32'd0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    #1;
    chk("err_cleared", 32'(err_unexpected), 32'd0);
    rx_frame(16'h1111, 1'b0, 1);
    #1;
    chk("err_set_wins", 32'(err_unexpected), 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    #1;
    chk("err_cleared2", 32'(err_unexpected), 32'd0);

    // Read accepted in the RX completion cycle.
    send_req(4'h6, 16'h0066, 1'b1);
    repeat (12) tick();
    rx_frame(16'hC0DE, 1'b1, 2);
    #1;
    chk("coincident_outstanding", 32'(outstanding), 32'd1);
    pop_check("coincident_resp");
    repeat (12) tick();
    rx_frame(16'h7E57, 1'b1, 0);
    #1;
    chk("pre_reset_outstanding", 32'(outstanding), 32'd0);
    chk("pre_reset_valid", 32'(bus.resp_valid), 32'd1);

    // Reset in the middle of a TX payload and an RX payload.
    send_req(4'h7, 16'h0077, 1'b1);
    rx_pins = 2'b00;
    tick();
    rx_pins = 2'b01;
    tick();
    rx_pins = 2'b10;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rx_pins = 2'b11;
    exp_q.delete();
    #1;
    chk("mid_rst_tx_pins", 32'(tx_pins), 32'h3);
    chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_pins%0d", i), 32'(tx_pins), 32'h3);
    end
    send_req(4'h8, 16'h0088, 1'b1);
    repeat (12) tick();
    rx_frame(16'h5A5A, 1'b1, 0);
    #1;
    chk("post_rst_outstanding", 32'(outstanding), 32'd0);
    chk("post_rst_err", 32'(err_unexpected), 32'd0);
    pop_check("post_rst_resp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
